// File: rtl/mc_datapath_regs.sv
// Register stage of the multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut,
// the unified-memory address mux, and two free-running debug counters.
module mc_datapath_regs #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter int               CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PCWrite,
  input  logic                 Branch,
  input  logic [1:0]           PCSrc,
  input  logic                 IRWrite,
  input  logic                 lord,
  input  logic                 Zero,
  input  logic [WIDTH-1:0]     ALUResult,
  input  logic [WIDTH-1:0]     ReadData,
  input  logic [WIDTH-1:0]     RD1,
  input  logic [WIDTH-1:0]     RD2,
  output logic [WIDTH-1:0]     PC,
  output logic [WIDTH-1:0]     Adr,
  output logic [WIDTH-1:0]     Instr,
  output logic [WIDTH-1:0]     Data,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [WIDTH-1:0]     ALUOut,
  output logic [CNT_WIDTH-1:0] CycleCount,
  output logic [CNT_WIDTH-1:0] InstrCount,
  output logic                 PCSrcErr
);

  logic             pc_en;
  logic [WIDTH-1:0] jump_target;

  assign pc_en       = PCWrite | (Branch & Zero);
  assign jump_target = {PC[WIDTH-1:WIDTH-4], Instr[WIDTH-7:0], 2'b00};
  assign Adr         = lord ? ALUOut : PC;

  // Reserved select 11 leaves PC alone and latches the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC       <= RESET_PC;
      PCSrcErr <= 1'b0;
    end else if (pc_en) begin
      case (PCSrc)
        2'b00: PC <= ALUResult;
        2'b01: PC <= ALUOut;
        2'b10: PC <= jump_target;
        2'b11: PCSrcErr <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Instr  <= '0;
      Data   <= '0;
      A      <= '0;
      B      <= '0;
      ALUOut <= '0;
    end else begin
      if (IRWrite) Instr <= ReadData;
      Data   <= ReadData;
      A      <= RD1;
      B      <= RD2;
      ALUOut <= ALUResult;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      CycleCount <= '0;
      InstrCount <= '0;
    end else begin
      CycleCount <= CycleCount + 1'b1;
      if (IRWrite) InstrCount <= InstrCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Randomized and directed bench for mc_datapath_regs against a behavioural model;
// a second instance with 4-bit counters exercises counter wrap.
module tb_mc_datapath_regs;

  logic        clk = 1'b0;
  logic        rst, pc_write, branch, ir_write, lord, zero;
  logic [1:0]  pc_src;
  logic [31:0] alu_result, read_data, rd1, rd2;

  logic [31:0] pc, adr, instr, data, a, b, alu_out, cycle_count, instr_count;
  logic        pc_src_err;
  logic [31:0] s_pc, s_adr, s_instr, s_data, s_a, s_b, s_alu_out;
  logic [3:0]  s_cycle_count, s_instr_count;
  logic        s_pc_src_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference state, updated from the architectural rules each edge.
  logic [31:0] m_pc, m_instr, m_data, m_a, m_b, m_alu_out;
  logic        m_err;
  longint      m_cyc, m_icnt;
  bit          m_valid = 0;

  always #5 clk = ~clk;

  mc_datapath_regs dut (
    .clk(clk), .rst(rst), .PCWrite(pc_write), .Branch(branch), .PCSrc(pc_src),
    .IRWrite(ir_write), .lord(lord), .Zero(zero), .ALUResult(alu_result),
    .ReadData(read_data), .RD1(rd1), .RD2(rd2), .PC(pc), .Adr(adr),
    .Instr(instr), .Data(data), .A(a), .B(b), .ALUOut(alu_out),
    .CycleCount(cycle_count), .InstrCount(instr_count), .PCSrcErr(pc_src_err)
  );

  mc_datapath_regs #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .PCWrite(pc_write), .Branch(branch), .PCSrc(pc_src),
    .IRWrite(ir_write), .lord(lord), .Zero(zero), .ALUResult(alu_result),
    .ReadData(read_data), .RD1(rd1), .RD2(rd2), .PC(s_pc), .Adr(s_adr),
    .Instr(s_instr), .Data(s_data), .A(s_a), .B(s_b), .ALUOut(s_alu_out),
    .CycleCount(s_cycle_count), .InstrCount(s_instr_count), .PCSrcErr(s_pc_src_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("pc", pc, m_pc);
    checkOutput("instr", instr, m_instr);
    checkOutput("data", data, m_data);
    checkOutput("a", a, m_a);
    checkOutput("b", b, m_b);
    checkOutput("alu_out", alu_out, m_alu_out);
    checkOutput("pc_src_err", {31'd0, pc_src_err}, {31'd0, m_err});
    checkOutput("cycle_count", cycle_count, m_cyc[31:0]);
    checkOutput("instr_count", instr_count, m_icnt[31:0]);
    checkOutput("s_cycle_count", {28'd0, s_cycle_count}, {28'd0, m_cyc[3:0]});
    checkOutput("s_instr_count", {28'd0, s_instr_count}, {28'd0, m_icnt[3:0]});
    checkOutput("s_pc", s_pc, m_pc);
    checkOutput("s_instr", s_instr, m_instr);
    checkOutput("s_adr", s_adr, lord ? m_alu_out : m_pc);
    checkOutput("s_dp", s_data ^ s_a ^ s_b ^ s_alu_out, m_data ^ m_a ^ m_b ^ m_alu_out);
    checkOutput("s_err", {31'd0, s_pc_src_err}, {31'd0, m_err});
  endtask

  // Drive one cycle of inputs from the negedge, check the combinational
  // address, take the edge, advance the model, and check every register.
  task automatic applyStimulus(input logic r, input logic pcw, input logic br,
                               input logic [1:0] src, input logic irw, input logic ld,
                               input logic z, input logic [31:0] alur,
                               input logic [31:0] rdat, input logic [31:0] r1,
                               input logic [31:0] r2);
    bit pcen;
    rst = r; pc_write = pcw; branch = br; pc_src = src; ir_write = irw;
    lord = ld; zero = z; alu_result = alur; read_data = rdat; rd1 = r1; rd2 = r2;
    #1;
    if (m_valid) checkOutput("adr", adr, ld ? m_alu_out : m_pc);
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 0; m_data = 0; m_a = 0; m_b = 0; m_alu_out = 0;
      m_err = 0; m_cyc = 0; m_icnt = 0; m_valid = 1;
    end else begin
      pcen = pcw || (br && z);
      if (pcen) begin
        if (src == 2'd0)      m_pc = alur;
        else if (src == 2'd1) m_pc = m_alu_out;
        else if (src == 2'd2) m_pc = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
        else                  m_err = 1;
      end
      if (irw) begin
        m_instr = rdat;
        m_icnt = (m_icnt + 1) % 64'h1_0000_0000;
      end
      m_cyc = (m_cyc + 1) % 64'h1_0000_0000;
      m_data = rdat; m_a = r1; m_b = r2; m_alu_out = alur;
    end
    #1;
    checkAll();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; pc_write = 0; branch = 0; pc_src = 0; ir_write = 0; lord = 0; zero = 0;
    alu_result = 0; read_data = 0; rd1 = 0; rd2 = 0;
    @(negedge clk);

    // Reset then fetch
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_adr", adr, 32'h0);
    applyStimulus(0, 1, 0, 2'b00, 1, 0, 0, 32'h4, 32'h8C01_0004, 0, 0);
    checkOutput("fetch_pc", pc, 32'h4);
    checkOutput("fetch_instr", instr, 32'h8C01_0004);
    checkOutput("fetch_icnt", instr_count, 32'd1);
    checkOutput("fetch_ccnt", cycle_count, 32'd1);

    // Branch not taken, taken, then PCWrite overriding a false Zero
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 32'h40, 0, 0, 0);
    applyStimulus(0, 0, 1, 2'b01, 0, 0, 0, 32'h40, 0, 0, 0);
    checkOutput("br_not_taken", pc, 32'h4);
    applyStimulus(0, 0, 1, 2'b01, 0, 0, 1, 32'h40, 0, 0, 0);
    checkOutput("br_taken", pc, 32'h40);
    applyStimulus(0, 1, 0, 2'b00, 0, 0, 0, 32'h8, 0, 0, 0);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 32'h40, 0, 0, 0);
    applyStimulus(0, 1, 1, 2'b01, 0, 0, 0, 32'h40, 0, 0, 0);
    checkOutput("pcw_br", pc, 32'h40);

    // Jump
    applyStimulus(0, 1, 0, 2'b00, 1, 0, 0, 32'hA000_0010, 32'h0800_0123, 0, 0);
    applyStimulus(0, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("jump_pc", pc, 32'hA000_048C);

    // lord address select and operand registers
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 32'h100, 0, 32'd5, 32'd7);
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0, 32'h100, 0, 32'd5, 32'd7);
    checkOutput("lord_adr", adr, 32'h100);
    checkOutput("a_reg", a, 32'd5);
    checkOutput("b_reg", b, 32'd7);

    // Reserved PCSrc with and without PCEn, then reset mid-op
    applyStimulus(0, 1, 0, 2'b11, 0, 0, 0, 32'h1234, 0, 0, 0);
    checkOutput("rsv_pc_hold", pc, 32'hA000_048C);
    checkOutput("rsv_err", {31'd0, pc_src_err}, 32'd1);
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rsv_no_en", {31'd0, pc_src_err}, 32'd0);
    applyStimulus(0, 1, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 2'b00, 1, 0, 0, 32'h55, 32'hDEAD_BEEF, 1, 2);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_err", {31'd0, pc_src_err}, 32'd0);
    checkOutput("rst_ccnt", cycle_count, 32'd0);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 0, 0, 2'b00, 1, 0, 0, 0, $urandom, 0, 0);
    checkOutput("wrap_ccnt", {28'd0, s_cycle_count}, 32'd0);
    checkOutput("wrap_icnt", {28'd0, s_instr_count}, 32'd0);
    checkOutput("nowrap_ccnt", cycle_count, 32'd16);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
                    2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom, $urandom, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
